// File: rtl/pipelined_cpu.sv
// pipelined_cpu: 5-stage in-order MIPS subset (IF, ID, EX, MEM, WB).
// Supported: add, sub, and, or, addi, lw, sw, beq, j; every other encoding is a NOP.
// Optional macro CPU_MUL_EN: when defined, R-type mul (funct 011000) is executed;
// when undefined, mul decodes as a NOP and no multiplier exists.
// start_i is a synchronous active-low reset. Instruction/data memories and the
// register file are loaded hierarchically and are never cleared by reset.

package pipelined_cpu_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  wreg;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  wreg;
    } mem_wb_t;
endpackage

module pc_reg (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        hold_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_d, pc_q;
    // PC freezes while the hazard unit stalls
    always_comb pc_d = hold_i ? pc_q : pc_i;
    // PC register, cleared to the reset fetch address
    always_ff @(posedge clk_i) begin
        if (!start_i) pc_q <= '0;
        else          pc_q <= pc_d;
    end
    assign pc_o = pc_q;
endmodule

module instr_mem (
    input  logic [7:0]  addr_i,
    output logic [31:0] instr_o
);
    logic [31:0] memory [0:255];
    assign instr_o = memory[addr_i];
endmodule

module data_mem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [7:0] memory [0:31];
    logic [4:0] base;
    assign base    = addr_i & 5'b11100;
    assign rdata_o = {memory[base + 5'd3], memory[base + 5'd2], memory[base + 5'd1], memory[base]};
    // little-endian word store
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[base]        <= wdata_i[7:0];
            memory[base + 5'd1] <= wdata_i[15:8];
            memory[base + 5'd2] <= wdata_i[23:16];
            memory[base + 5'd3] <= wdata_i[31:24];
        end
    end
endmodule

module reg_file (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  wreg_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o
);
    logic [31:0] register [0:31];
    // combinational read with same-cycle write-back bypass
    always_comb begin
        rs_data_o = register[rs_i];
        rt_data_o = register[rt_i];
        if (we_i && wreg_i != 5'd0 && wreg_i == rs_i) rs_data_o = wdata_i;
        if (we_i && wreg_i != 5'd0 && wreg_i == rt_i) rt_data_o = wdata_i;
    end
    // write-back port; $0 stays hard-wired to its loaded value
    always_ff @(posedge clk_i) begin
        if (we_i && wreg_i != 5'd0) register[wreg_i] <= wdata_i;
    end
endmodule

module if_id_reg (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        Flush_i,
    input  logic        hold_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o
);
    logic [31:0] instr_d, instr_q, pc4_d, pc4_q;
    // flush inserts a NOP, stall holds, otherwise capture the fetch
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (Flush_i) begin
            instr_d = '0;
            pc4_d   = '0;
        end else if (!hold_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
        end
    end
    // IF/ID register
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
endmodule

module control_unit
    import pipelined_cpu_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic       reg_dst_o,
    output logic       Jump_o,
    output logic       Branch_o
);
    // opcode/funct decode; anything unrecognised leaves all controls at 0
    always_comb begin
        ctrl_o    = '0;
        reg_dst_o = 1'b0;
        Jump_o    = 1'b0;
        Branch_o  = 1'b0;
        case (op_i)
            6'b000000: begin
                reg_dst_o        = 1'b1;
                ctrl_o.reg_write = 1'b1;
                case (funct_i)
                    6'b100000: ctrl_o.alu_op = ALU_ADD;
                    6'b100010: ctrl_o.alu_op = ALU_SUB;
                    6'b100100: ctrl_o.alu_op = ALU_AND;
                    6'b100101: ctrl_o.alu_op = ALU_OR;
`ifdef CPU_MUL_EN
                    6'b011000: ctrl_o.alu_op = ALU_MUL;
`endif
                    default:   ctrl_o.reg_write = 1'b0;
                endcase
            end
            6'b001000: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            6'b100011: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.alu_src    = 1'b1;
            end
            6'b101011: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
            end
            6'b000100: Branch_o = 1'b1;
            6'b000010: Jump_o   = 1'b1;
            default: ;
        endcase
    end
endmodule

module hazard_unit (
    input  logic       run_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_branch_i,
    input  logic       id_jump_i,
    input  logic       idex_reg_write_i,
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_wreg_i,
    input  logic       exmem_mem_read_i,
    input  logic [4:0] exmem_wreg_i,
    output logic       stall_o,
    output logic       MuxSelect_o
);
    logic idex_hit, exmem_hit;
    // load-use stall, plus beq waiting for operands it cannot get by forwarding
    always_comb begin
        idex_hit  = (idex_wreg_i == id_rs_i) || (idex_wreg_i == id_rt_i);
        exmem_hit = (exmem_wreg_i == id_rs_i) || (exmem_wreg_i == id_rt_i);
        stall_o   = idex_mem_read_i && idex_hit;
        if (id_branch_i && ((idex_reg_write_i && idex_wreg_i != 5'd0 && idex_hit)
                            || (exmem_mem_read_i && exmem_hit)))
            stall_o = 1'b1;
        stall_o     = stall_o && run_i;
        MuxSelect_o = run_i && (stall_o || id_branch_i || id_jump_i);
    end
endmodule

module pipelined_cpu
    import pipelined_cpu_pkg::*;
(
    input logic clk_i,
    input logic start_i
);
    logic [31:0] pc, pc_plus4, pc_next, if_instr, id_instr, id_pc4, id_imm;
    logic [31:0] id_rs_data, id_rt_data, cmp_a, cmp_b;
    logic [31:0] fwd_a, fwd_b, op_b, alu, mem_rdata, wb_data;
    logic [4:0]  id_rs, id_rt;
    logic        stall, flush, mux_select, take, id_reg_dst, id_jump, id_branch, wb_we;
    ctrl_t       id_ctrl;
    id_ex_t      idex_d, idex_q;
    ex_mem_t     exmem_d, exmem_q;
    mem_wb_t     memwb_d, memwb_q;

    assign id_rs   = id_instr[25:21];
    assign id_rt   = id_instr[20:16];
    assign id_imm  = {{16{id_instr[15]}}, id_instr[15:0]};
    assign wb_data = memwb_q.mem_to_reg ? memwb_q.mem : memwb_q.alu;
    assign wb_we   = start_i && memwb_q.reg_write;

    pc_reg PC (.clk_i(clk_i), .start_i(start_i), .hold_i(stall), .pc_i(pc_next), .pc_o(pc));

    instr_mem Instruction_Memory (.addr_i(pc[9:2]), .instr_o(if_instr));

    if_id_reg IF_ID (.clk_i(clk_i), .start_i(start_i), .Flush_i(flush), .hold_i(stall),
                     .instr_i(if_instr), .pc4_i(pc_plus4), .instr_o(id_instr), .pc4_o(id_pc4));

    control_unit Control (.op_i(id_instr[31:26]), .funct_i(id_instr[5:0]), .ctrl_o(id_ctrl),
                          .reg_dst_o(id_reg_dst), .Jump_o(id_jump), .Branch_o(id_branch));

    reg_file Registers (.clk_i(clk_i), .we_i(wb_we), .rs_i(id_rs), .rt_i(id_rt),
                        .wreg_i(memwb_q.wreg), .wdata_i(wb_data),
                        .rs_data_o(id_rs_data), .rt_data_o(id_rt_data));

    hazard_unit Hazard_Detection (.run_i(start_i), .id_rs_i(id_rs), .id_rt_i(id_rt),
                                  .id_branch_i(id_branch), .id_jump_i(id_jump),
                                  .idex_reg_write_i(idex_q.ctrl.reg_write),
                                  .idex_mem_read_i(idex_q.ctrl.mem_read), .idex_wreg_i(idex_q.wreg),
                                  .exmem_mem_read_i(exmem_q.mem_read), .exmem_wreg_i(exmem_q.wreg),
                                  .stall_o(stall), .MuxSelect_o(mux_select));

    data_mem Data_Memory (.clk_i(clk_i), .we_i(start_i && exmem_q.mem_write),
                          .addr_i(exmem_q.alu[4:0]), .wdata_i(exmem_q.store), .rdata_o(mem_rdata));

    // ID-stage beq compare (EX/MEM ALU forwarding) and next-PC selection
    always_comb begin
        cmp_a = id_rs_data;
        cmp_b = id_rt_data;
        if (exmem_q.reg_write && exmem_q.wreg != 5'd0) begin
            if (exmem_q.wreg == id_rs) cmp_a = exmem_q.alu;
            if (exmem_q.wreg == id_rt) cmp_b = exmem_q.alu;
        end
        take     = id_branch && (cmp_a == cmp_b);
        flush    = start_i && !stall && (id_jump || take);
        pc_plus4 = pc + 32'd4;
        pc_next  = pc_plus4;
        if (id_jump)   pc_next = {id_pc4[31:28], id_instr[25:0], 2'b00};
        else if (take) pc_next = id_pc4 + {id_imm[29:0], 2'b00};
    end

    // ID/EX payload; a bubble (all zero) on stall, beq or j
    always_comb begin
        idex_d = '0;
        if (!mux_select) begin
            idex_d.ctrl    = id_ctrl;
            idex_d.rs_data = id_rs_data;
            idex_d.rt_data = id_rt_data;
            idex_d.imm     = id_imm;
            idex_d.rs      = id_rs;
            idex_d.rt      = id_rt;
            idex_d.wreg    = id_reg_dst ? id_instr[15:11] : id_rt;
        end
    end

    // EX: operand forwarding (EX/MEM wins over MEM/WB) and ALU
    always_comb begin
        fwd_a = idex_q.rs_data;
        fwd_b = idex_q.rt_data;
        if (memwb_q.reg_write && memwb_q.wreg != 5'd0) begin
            if (memwb_q.wreg == idex_q.rs) fwd_a = wb_data;
            if (memwb_q.wreg == idex_q.rt) fwd_b = wb_data;
        end
        if (exmem_q.reg_write && exmem_q.wreg != 5'd0) begin
            if (exmem_q.wreg == idex_q.rs) fwd_a = exmem_q.alu;
            if (exmem_q.wreg == idex_q.rt) fwd_b = exmem_q.alu;
        end
        op_b = idex_q.ctrl.alu_src ? idex_q.imm : fwd_b;
        case (idex_q.ctrl.alu_op)
            ALU_SUB: alu = fwd_a - op_b;
            ALU_AND: alu = fwd_a & op_b;
            ALU_OR:  alu = fwd_a | op_b;
`ifdef CPU_MUL_EN
            ALU_MUL: alu = fwd_a * op_b;
`endif
            default: alu = fwd_a + op_b;
        endcase
        exmem_d            = '0;
        exmem_d.reg_write  = idex_q.ctrl.reg_write;
        exmem_d.mem_read   = idex_q.ctrl.mem_read;
        exmem_d.mem_write  = idex_q.ctrl.mem_write;
        exmem_d.mem_to_reg = idex_q.ctrl.mem_to_reg;
        exmem_d.alu        = alu;
        exmem_d.store      = fwd_b;
        exmem_d.wreg       = idex_q.wreg;
    end

    // MEM/WB payload
    always_comb begin
        memwb_d            = '0;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.alu        = exmem_q.alu;
        memwb_d.mem        = mem_rdata;
        memwb_d.wreg       = exmem_q.wreg;
    end

    // ID/EX, EX/MEM and MEM/WB registers
    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu: programs are loaded hierarchically,
// results are compared with hand-computed values.
module tb_pipelined_cpu;
    logic clk = 1'b0;
    logic start_i = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    int   flush_cnt = 0;
    int   mux_cnt = 0;

    pipelined_cpu dut (.clk_i(clk), .start_i(start_i));

    always #5 clk = ~clk;

    // event counters sampled mid-cycle
    always @(negedge clk) begin
        if (start_i) begin
            if (dut.Hazard_Detection.MuxSelect_o && !dut.Control.Jump_o && !dut.Control.Branch_o)
                stall_cnt++;
            if (dut.Hazard_Detection.MuxSelect_o) mux_cnt++;
            if (dut.IF_ID.Flush_i) flush_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold_reset();
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] <= 32'h0;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        dut.Instruction_Memory.memory[addr / 4] <= w;
    endtask

    task automatic set_reg(input int r, input logic [31:0] v);
        dut.Registers.register[r] <= v;
    endtask

    task automatic set_mem(input int a, input logic [7:0] v);
        dut.Data_Memory.memory[a] <= v;
    endtask

    task automatic go(input int cycles);
        #1;
        stall_cnt = 0;
        flush_cnt = 0;
        mux_cnt   = 0;
        start_i   = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // ---- reset behaviour and sequential fetch ----
        clear_imem();
        for (int i = 0; i < 32; i++) set_reg(i, 32'h0);
        for (int i = 0; i < 32; i++) set_mem(i, 8'h0);
        set_reg(5, 32'h1234);
        set_mem(3, 8'h77);
        start_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("pc_in_reset", dut.PC.pc_o, 32'h0);
        end
        start_i = 1'b1;
        check("pc_first_fetch", dut.PC.pc_o, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("pc_advance", dut.PC.pc_o, 32'(4 * k));
        end
        check("reg5_kept", dut.Registers.register[5], 32'h1234);
        check("dmem3_kept", {24'h0, dut.Data_Memory.memory[3]}, 32'h77);

        // ---- addi then dependent add: forwarding, no stall ----
        hold_reset();
        clear_imem();
        set_reg(8, 0); set_reg(9, 0);
        put(0, 32'h20080005);             // addi $8,$0,5
        put(4, 32'h01084820);             // add  $9,$8,$8
        go(12);
        check("fwd_r8", dut.Registers.register[8], 32'd5);
        check("fwd_r9", dut.Registers.register[9], 32'd10);
        check("fwd_stalls", 32'(stall_cnt), 32'd0);

        // ---- load-use: one stall ----
        hold_reset();
        clear_imem();
        set_reg(8, 0); set_reg(9, 0);
        set_mem(0, 8'h05); set_mem(1, 8'h00); set_mem(2, 8'h00); set_mem(3, 8'h00);
        put(0, 32'h8C080000);             // lw  $8,0($0)
        put(4, 32'h01084820);             // add $9,$8,$8
        go(12);
        check("lu_r8", dut.Registers.register[8], 32'd5);
        check("lu_r9", dut.Registers.register[9], 32'd10);
        check("lu_stalls", 32'(stall_cnt), 32'd1);

        // ---- store word, then load it back ----
        hold_reset();
        clear_imem();
        set_reg(9, 32'd10); set_reg(10, 32'h0);
        set_mem(3, 8'h55); set_mem(8, 8'h55);
        for (int i = 4; i < 8; i++) set_mem(i, 8'hEE);
        put(0, 32'hAC090004);             // sw $9,4($0)
        put(4, 32'h8C0A0004);             // lw $10,4($0)
        go(12);
        check("sw_b4", {24'h0, dut.Data_Memory.memory[4]}, 32'h0A);
        check("sw_b5", {24'h0, dut.Data_Memory.memory[5]}, 32'h00);
        check("sw_b6", {24'h0, dut.Data_Memory.memory[6]}, 32'h00);
        check("sw_b7", {24'h0, dut.Data_Memory.memory[7]}, 32'h00);
        check("sw_b3_untouched", {24'h0, dut.Data_Memory.memory[3]}, 32'h55);
        check("sw_b8_untouched", {24'h0, dut.Data_Memory.memory[8]}, 32'h55);
        check("lw_back_r10", dut.Registers.register[10], 32'd10);

        // ---- taken beq and j: PC trace, flushes ----
        hold_reset();
        clear_imem();
        for (int r = 11; r <= 14; r++) set_reg(r, 32'h0);
        put(8,    32'h10000002);          // beq $0,$0,+2 -> 20
        put(12,   32'h200B0007);          // addi $11 (flushed)
        put(16,   32'h200C0009);          // addi $12 (skipped)
        put(20,   32'h08000010);          // j 0x10 -> 0x40
        put(24,   32'h200D0001);          // addi $13 (flushed)
        put(64,   32'h200E0003);          // addi $14,$0,3
        #1;
        stall_cnt = 0; flush_cnt = 0; mux_cnt = 0;
        start_i = 1'b1;
        check("br_pc0", dut.PC.pc_o, 32'h0);
        begin
            logic [31:0] exp_pc [0:6];
            exp_pc = '{32'd4, 32'd8, 32'd12, 32'd20, 32'd24, 32'h40, 32'h44};
            for (int k = 0; k < 7; k++) begin
                @(posedge clk);
                #1;
                check("br_pc_trace", dut.PC.pc_o, exp_pc[k]);
            end
        end
        repeat (8) @(posedge clk);
        #1;
        check("br_flushes", 32'(flush_cnt), 32'd2);
        check("br_stalls", 32'(stall_cnt), 32'd0);
        check("br_muxsel", 32'(mux_cnt), 32'd2);
        check("br_r11", dut.Registers.register[11], 32'h0);
        check("br_r12", dut.Registers.register[12], 32'h0);
        check("br_r13", dut.Registers.register[13], 32'h0);
        check("br_r14", dut.Registers.register[14], 32'd3);

        // ---- reset while j sits in ID ----
        hold_reset();
        go(5);
        check("j_in_id_flush", {31'h0, dut.IF_ID.Flush_i}, 32'h1);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pc", dut.PC.pc_o, 32'h0);
        check("rst_flush", {31'h0, dut.IF_ID.Flush_i}, 32'h0);
        check("rst_muxsel", {31'h0, dut.Hazard_Detection.MuxSelect_o}, 32'h0);
        check("rst_ifid", dut.IF_ID.instr_o, 32'h0);

        // ---- mul ----
        hold_reset();
        clear_imem();
        set_reg(8, 32'd3); set_reg(9, 32'd4); set_reg(10, 32'h55);
        put(0, 32'h01095018);             // mul $10,$8,$9
        go(10);
`ifdef CPU_MUL_EN
        check("mul_r10", dut.Registers.register[10], 32'd12);
`else
        check("mul_r10", dut.Registers.register[10], 32'h55);
`endif

        // ---- mixed ALU ops, forwarding paths, $0, beq stall ----
        hold_reset();
        clear_imem();
        for (int r = 8; r <= 18; r++) set_reg(r, 32'h0);
        set_reg(15, 32'h55);
        put(0,  32'h2008FFFF);            // addi $8,$0,-1
        put(4,  32'h20090006);            // addi $9,$0,6
        put(8,  32'h01285022);            // sub  $10,$9,$8  = 7
        put(12, 32'h01095824);            // and  $11,$8,$9  = 6
        put(16, 32'h01496025);            // or   $12,$10,$9 = 7
        put(20, 32'h20000009);            // addi $0,$0,9
        put(24, 32'h01086820);            // add  $13,$8,$8  = fffffffe
        put(28, 32'h200E0007);            // addi $14,$0,7
        put(32, 32'h11CA0001);            // beq  $14,$10,+1 (stall, taken)
        put(36, 32'h200F0001);            // addi $15 (skipped)
        put(40, 32'h11090001);            // beq  $8,$9,+1 (not taken)
        put(44, 32'h20100002);            // addi $16,$0,2
        put(48, 32'h20110001);            // addi $17,$0,1
        put(52, 32'h20110002);            // addi $17,$0,2
        put(56, 32'h02319020);            // add  $18,$17,$17 = 4
        go(30);
        check("mix_r8", dut.Registers.register[8], 32'hFFFFFFFF);
        check("mix_sub", dut.Registers.register[10], 32'd7);
        check("mix_and", dut.Registers.register[11], 32'd6);
        check("mix_or", dut.Registers.register[12], 32'd7);
        check("mix_r0", dut.Registers.register[0], 32'h0);
        check("mix_wrap", dut.Registers.register[13], 32'hFFFFFFFE);
        check("mix_r14", dut.Registers.register[14], 32'd7);
        check("mix_skip_r15", dut.Registers.register[15], 32'h55);
        check("mix_r16", dut.Registers.register[16], 32'd2);
        check("mix_prio_r18", dut.Registers.register[18], 32'd4);
        check("mix_flushes", 32'(flush_cnt), 32'd1);
        check("mix_stalls", 32'(stall_cnt), 32'd0);
        check("mix_muxsel", 32'(mux_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_cpu.md
PIPELINED_CPU -- requirements
Module: pipelined_cpu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i  input  1  rising-edge clock; start_i  input  1  synchronous active-low reset (0 = held in reset, 1 = run).
REQ-002 The block SHALL have no other ports; all state SHALL be observable hierarchically.
REQ-003 The following hierarchical names SHALL exist:
- PC.pc_o: 32-bit current fetch PC.
- Instruction_Memory.memory[0:255]: 32-bit words.
- Data_Memory.memory[0:31]: bytes.
- Registers.register[0:31]: 32-bit.
- Hazard_Detection.MuxSelect_o: bubble select.
- IF_ID.Flush_i: IF/ID flush.
- Control.Jump_o and Control.Branch_o: decoded in ID.

Function
REQ-004 The block SHALL be a 5-stage in-order MIPS pipeline (IF, ID, EX, MEM, WB) with IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-005 Supported instructions SHALL be:
- R-type op 000000 with funct add 100000, sub 100010, and 100100, or 100101, mul 011000.
- addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
- All other encodings SHALL execute as NOPs.
REQ-006 Instruction fetch SHALL read Instruction_Memory.memory[PC[9:2]]; the sequential next PC SHALL be PC+4.
REQ-007 Data memory SHALL hold 32 bytes, be little-endian, and use word access at byte address ALU[4:0] & 5'b11100; lw reads and sw writes memory[a+3..a] as {b3,b2,b1,b0}.
REQ-008 Register file reads SHALL be combinational. Writes SHALL occur on the clock edge from WB. A same-cycle WB write to a register being read SHALL be bypassed to the read. register[0] SHALL never be written.
REQ-009 Arithmetic SHALL be 32-bit two's complement with wrap-around and no overflow trap; mul SHALL keep the low 32 bits; addi/lw/sw immediates SHALL be sign-extended.
REQ-010 EX forwarding SHALL select EX/MEM result over MEM/WB result, and either over the register value, when the producer has RegWrite and rd != 0.
REQ-011 Load-use hazard (ID/EX is lw and its rt equals ID rs or rt): MuxSelect_o=1 for one cycle; PC and IF/ID hold; a bubble (all controls 0) enters ID/EX.
REQ-012 beq SHALL resolve in ID using a comparator fed from the register file with EX/MEM ALU forwarding.
REQ-013 beq SHALL stall one cycle while a source register matches an ALU writer in ID/EX, and SHALL stall while a source matches a load in ID/EX or EX/MEM.
REQ-014 Taken beq SHALL set the next PC to PC+4+(sext(imm)<<2). j SHALL set the next PC to {PC+4[31:28], target, 2'b00}. Either SHALL assert IF_ID.Flush_i for one cycle, zeroing IF/ID (1 bubble).
REQ-015 When a stall and a flush coincide, the stall SHALL win and the flush SHALL be re-evaluated next cycle.
REQ-016 MuxSelect_o SHALL also assert on a cycle where Jump_o or Branch_o is 1 (control zeroing into ID/EX); stall counting SHALL exclude those cycles.
REQ-017 PC SHALL wrap modulo 2^32; the instruction index SHALL wrap modulo 256.

Reset
REQ-018 While start_i=0 at a rising edge:
- PC SHALL be set to 0.
- All pipeline registers SHALL be cleared to NOP/zero controls.
- Flush and stall SHALL be 0.
REQ-019 Reset SHALL NOT clear Instruction_Memory, Data_Memory or Registers; these are loaded externally.
REQ-020 After start_i rises, the first fetch SHALL be address 0 and PC SHALL advance by 4 each unstalled cycle.

Configuration
REQ-021 Macro CPU_MUL_EN SHALL control mul support.
- Defined: mul (funct 011000) SHALL be executed.
- Undefined: mul SHALL be decoded as a NOP (no register write) and no multiplier SHALL be synthesized.

Verification
REQ-022 start_i=0 for 3 edges, then 1 -> PC=0 during reset, then 0,4,8,12; registers and memories unchanged.
REQ-023 addi $8,$0,5; add $9,$8,$8 -> $9=10; zero stalls (forwarding).
REQ-024 Data_Memory[0]=5; lw $8,0($0); add $9,$8,$8 -> exactly 1 stall; $9=10.
REQ-025 sw $9,4($0) with $9=10 -> memory[4]=8'h0A, memory[5..7]=0; word at 0x04 reads 10.
REQ-026 At PC=8, beq $0,$0,+2 -> next fetch PC=20; flush count +1; instruction at 12 has no effect. j 0x10 -> PC=0x40; flush +1.
REQ-027 $8=3, $9=4; mul $10,$8,$9 -> $10=12 with CPU_MUL_EN; $10 unchanged without it.
